// File: rtl/draw_square_hl.sv
// Cell highlighter for the 3x3 board overlay: fills or outlines any selected cells,
// with optional frame-locked blinking. Every output is registered, giving one pclk of latency.
module draw_square_hl #(
   parameter int          GRID_X0      = 0,
   parameter int          GRID_Y0      = 0,
   parameter int          CELL_W       = 341,
   parameter int          CELL_H       = 256,
   parameter int          BORDER       = 8,
   parameter logic [11:0] HL_COLOR     = 12'hff0,
   parameter int          BLINK_FRAMES = 30
) (
   input  logic        pclk,
   input  logic        rst,
   input  logic [10:0] hcount_in,
   input  logic [10:0] vcount_in,
   input  logic        hsync_in,
   input  logic        vsync_in,
   input  logic        hblnk_in,
   input  logic        vblnk_in,
   input  logic [11:0] rgb_in,
   input  logic        start_en,
   input  logic [8:0]  sel,
   input  logic        outline_en,
   input  logic        blink_en,
   output logic [10:0] hcount_out,
   output logic [10:0] vcount_out,
   output logic        hsync_out,
   output logic        vsync_out,
   output logic        hblnk_out,
   output logic        vblnk_out,
   output logic [11:0] rgb_out
);

   localparam int                CNT_W    = $clog2(BLINK_FRAMES + 1);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(BLINK_FRAMES - 1);

   typedef enum logic {PH_OFF = 1'b0, PH_ON = 1'b1} phase_t;

   phase_t           phase_q, phase_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [8:0]       sel_q, sel_d;
   logic             vsync_dly_q;
   logic [11:0]      rgb_d;

   int         x, y;
   logic [2:0] col_hit, row_hit, col_edge, row_edge;
   logic [8:0] cell_hl;
   logic       frame_edge, blink_run, phase_on, draw;

   assign x = {21'd0, hcount_in};
   assign y = {21'd0, vcount_in};

   // Edge flags are only meaningful when the matching hit flag is set.
   generate
      for (genvar gi = 0; gi < 3; gi++) begin : g_axis
         localparam int XL = GRID_X0 + gi * CELL_W;
         localparam int XH = GRID_X0 + (gi + 1) * CELL_W - 1;
         localparam int YL = GRID_Y0 + gi * CELL_H;
         localparam int YH = GRID_Y0 + (gi + 1) * CELL_H - 1;
         assign col_hit[gi]  = (x >= XL) && (x <= XH);
         assign row_hit[gi]  = (y >= YL) && (y <= YH);
         assign col_edge[gi] = ((x - XL) < BORDER) || ((XH - x) < BORDER);
         assign row_edge[gi] = ((y - YL) < BORDER) || ((YH - y) < BORDER);
      end
      for (genvar gi = 0; gi < 9; gi++) begin : g_cell
         assign cell_hl[gi] = sel_q[gi] && row_hit[gi/3] && col_hit[gi%3]
                              && (!outline_en || row_edge[gi/3] || col_edge[gi%3]);
      end
   endgenerate

   assign frame_edge = vsync_in && !vsync_dly_q;
   assign blink_run  = start_en && blink_en;

   always_comb begin
      cnt_d   = cnt_q;
      phase_d = phase_q;
      sel_d   = frame_edge ? sel : sel_q;
      if (!blink_run) begin
         cnt_d   = '0;
         phase_d = PH_ON;
      end else if (frame_edge) begin
         if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            phase_d = (phase_q == PH_ON) ? PH_OFF : PH_ON;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
      // Disabling blink shows the highlight on the very next pixel.
      phase_on = (phase_q == PH_ON) || !blink_run;
      draw     = start_en && phase_on && !hblnk_in && !vblnk_in && (|cell_hl);
      rgb_d    = draw ? HL_COLOR : rgb_in;
   end

   always_ff @(posedge pclk or posedge rst) begin
      if (rst) begin
         phase_q     <= PH_ON;
         cnt_q       <= '0;
         sel_q       <= '0;
         vsync_dly_q <= 1'b0;
         hcount_out  <= '0;
         vcount_out  <= '0;
         hsync_out   <= 1'b0;
         vsync_out   <= 1'b0;
         hblnk_out   <= 1'b0;
         vblnk_out   <= 1'b0;
         rgb_out     <= '0;
      end else begin
         phase_q     <= phase_d;
         cnt_q       <= cnt_d;
         sel_q       <= sel_d;
         vsync_dly_q <= vsync_in;
         hcount_out  <= hcount_in;
         vcount_out  <= vcount_in;
         hsync_out   <= hsync_in;
         vsync_out   <= vsync_in;
         hblnk_out   <= hblnk_in;
         vblnk_out   <= vblnk_in;
         rgb_out     <= rgb_d;
      end
   end

endmodule
